// File: rtl/remote_link_rx_pkg.sv
// Shared definitions for the board-to-board key link receiver: design-wide
// defaults and the per-channel output bundle.
package remote_link_rx_pkg;

    localparam int unsigned LINK_DEBOUNCE_CYCLES = 65000;
    localparam int unsigned LINK_SYNC_STAGES     = 2;

    typedef struct packed {
        logic level;
        logic press;
        logic rel;
    } link_chan_t;

endpackage : remote_link_rx_pkg

// File: rtl/link_debounce.sv
// One link channel: synchroniser chain, persistence-count debouncer, and
// registered single-cycle press/release pulses.
module link_debounce
    import remote_link_rx_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = LINK_SYNC_STAGES,
    parameter int unsigned DEBOUNCE_CYCLES = LINK_DEBOUNCE_CYCLES
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    output link_chan_t chan_o
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   stable_q, stable_d;
    logic                   press_q, press_d;
    logic                   release_q, release_d;
    logic                   sync_c;

    assign sync_c = sync_q[SYNC_STAGES-1];

    // Accept a new value only after it persists for DEBOUNCE_CYCLES samples.
    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], rx_i};
        stable_d  = stable_q;
        cnt_d     = '0;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (sync_c != stable_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                stable_d  = sync_c;
                press_d   = sync_c;
                release_d = ~sync_c;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q    <= '0;
            cnt_q     <= '0;
            stable_q  <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            cnt_q     <= cnt_d;
            stable_q  <= stable_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign chan_o = '{level: stable_q, press: press_q, rel: release_q};

endmodule : link_debounce

// File: rtl/remote_link_rx.sv
// Conditions the opponent's raw SPACE and ENTER link pins into clean levels
// and edge pulses for the turn and game FSMs.
module remote_link_rx
    import remote_link_rx_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = LINK_SYNC_STAGES,
    parameter int unsigned DEBOUNCE_CYCLES = LINK_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic space_rx,
    input  logic enter_rx,
    output logic space_level,
    output logic enter_level,
    output logic space_press,
    output logic space_release,
    output logic enter_press,
    output logic enter_release
);

    link_chan_t space_chan;
    link_chan_t enter_chan;

    link_debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_space (
        .clk_i (clk),
        .rst_i (rst),
        .rx_i  (space_rx),
        .chan_o(space_chan)
    );

    link_debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_enter (
        .clk_i (clk),
        .rst_i (rst),
        .rx_i  (enter_rx),
        .chan_o(enter_chan)
    );

    assign space_level   = space_chan.level;
    assign space_press   = space_chan.press;
    assign space_release = space_chan.rel;
    assign enter_level   = enter_chan.level;
    assign enter_press   = enter_chan.press;
    assign enter_release = enter_chan.rel;

endmodule : remote_link_rx

// File: tb/tb_remote_link_rx.sv
// Bench for remote_link_rx: directed scenarios plus random line activity,
// every cycle compared against a behavioural model of the link rules.
module tb_remote_link_rx;

    localparam int unsigned D = 8;
    localparam int unsigned S = 2;

    logic clk = 1'b0;
    logic rst, space_rx, enter_rx;
    logic space_level, enter_level, space_press, space_release, enter_press, enter_release;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    // Observation counters for the directed scenarios.
    int sp_press_cnt, sp_press_edge, sp_rel_cnt, sp_rel_edge;
    int en_press_cnt, en_press_edge, en_rel_cnt, en_rel_edge, en_level_hi;

    // Model: per channel, delayed raw samples, accepted level, and how many
    // consecutive samples have disagreed with the accepted level.
    bit m_pipe[2][S];
    bit m_level[2];
    int m_run[2];
    bit m_press[2];
    bit m_rel[2];

    remote_link_rx #(.SYNC_STAGES(S), .DEBOUNCE_CYCLES(D)) dut (
        .clk          (clk),
        .rst          (rst),
        .space_rx     (space_rx),
        .enter_rx     (enter_rx),
        .space_level  (space_level),
        .enter_level  (enter_level),
        .space_press  (space_press),
        .space_release(space_release),
        .enter_press  (enter_press),
        .enter_release(enter_release)
    );

    always #5 clk = ~clk;

    task automatic model_edge(input bit r, input bit raw0, input bit raw1);
        bit raw[2];
        bit seen;
        raw[0] = raw0;
        raw[1] = raw1;
        for (int ch = 0; ch < 2; ch++) begin
            m_press[ch] = 1'b0;
            m_rel[ch]   = 1'b0;
            if (r) begin
                m_level[ch] = 1'b0;
                m_run[ch]   = 0;
                for (int k = 0; k < S; k++) m_pipe[ch][k] = 1'b0;
            end else begin
                seen = m_pipe[ch][S-1];
                if (seen != m_level[ch]) begin
                    m_run[ch]++;
                    if (m_run[ch] == D) begin
                        m_level[ch] = seen;
                        m_press[ch] = seen;
                        m_rel[ch]   = !seen;
                        m_run[ch]   = 0;
                    end
                end else begin
                    m_run[ch] = 0;
                end
                for (int k = S - 1; k > 0; k--) m_pipe[ch][k] = m_pipe[ch][k-1];
                m_pipe[ch][0] = raw[ch];
            end
        end
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at edge %0d: observed %b expected %b", tag, edge_n, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs == exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_obs();
        edge_n = 0;
        sp_press_cnt = 0; sp_press_edge = -1; sp_rel_cnt = 0; sp_rel_edge = -1;
        en_press_cnt = 0; en_press_edge = -1; en_rel_cnt = 0; en_rel_edge = -1;
        en_level_hi = 0;
    endtask

    // One clock: advance the model with the inputs the DUT sampled, then compare.
    task automatic step();
        @(posedge clk);
        model_edge(rst, space_rx, enter_rx);
        edge_n++;
        #1;
        chk("space_level",   space_level,   m_level[0]);
        chk("space_press",   space_press,   m_press[0]);
        chk("space_release", space_release, m_rel[0]);
        chk("enter_level",   enter_level,   m_level[1]);
        chk("enter_press",   enter_press,   m_press[1]);
        chk("enter_release", enter_release, m_rel[1]);
        if (space_press === 1'b1)   begin sp_press_cnt++; if (sp_press_edge < 0) sp_press_edge = edge_n; end
        if (space_release === 1'b1) begin sp_rel_cnt++;   if (sp_rel_edge < 0)   sp_rel_edge   = edge_n; end
        if (enter_press === 1'b1)   begin en_press_cnt++; if (en_press_edge < 0) en_press_edge = edge_n; end
        if (enter_release === 1'b1) begin en_rel_cnt++;   if (en_rel_edge < 0)   en_rel_edge   = edge_n; end
        if (enter_level === 1'b1) en_level_hi++;
    endtask

    initial begin
        int last_rise;
        int hold_s;
        int hold_e;
        bit prev;

        rst = 1'b1; space_rx = 1'b0; enter_rx = 1'b0;
        clear_obs();
        repeat (2) step();
        chk("reset_space_level", space_level, 1'b0);
        chk("reset_enter_level", enter_level, 1'b0);
        rst = 1'b0;
        repeat (3) step();

        // Clean press on SPACE.
        clear_obs();
        space_rx = 1'b1;
        repeat (14) step();
        chk_int("clean_press_edge",  sp_press_edge, S + D);
        chk_int("clean_press_count", sp_press_cnt, 1);
        chk_int("clean_release_count", sp_rel_cnt, 0);
        chk("clean_level_high", space_level, 1'b1);

        // Release on SPACE.
        clear_obs();
        space_rx = 1'b0;
        repeat (14) step();
        chk_int("release_edge",  sp_rel_edge, S + D);
        chk_int("release_count", sp_rel_cnt, 1);
        chk_int("release_press_count", sp_press_cnt, 0);

        // Glitch one cycle short of acceptance on ENTER.
        clear_obs();
        enter_rx = 1'b1;
        repeat (D - 1) step();
        enter_rx = 1'b0;
        repeat (12) step();
        chk_int("glitch_level_high_cycles", en_level_hi, 0);
        chk_int("glitch_press_count", en_press_cnt, 0);
        chk_int("glitch_release_count", en_rel_cnt, 0);

        // Bounce for 30 cycles, then settle high.
        clear_obs();
        last_rise = -1;
        prev = 1'b0;
        for (int i = 0; i < 30; i++) begin
            space_rx = ((i / 3) % 2) == 0;
            if (space_rx && !prev) last_rise = edge_n + 1;
            prev = space_rx;
            step();
        end
        space_rx = 1'b1;
        if (!prev) last_rise = edge_n + 1;
        repeat (14) step();
        chk_int("bounce_press_count", sp_press_cnt, 1);
        chk_int("bounce_press_edge", sp_press_edge, last_rise + S + D - 1);
        chk_int("bounce_release_count", sp_rel_cnt, 0);

        clear_obs();
        space_rx = 1'b0;
        repeat (14) step();
        chk_int("bounce_release_edge", sp_rel_edge, S + D);

        // Both lines rise together.
        clear_obs();
        space_rx = 1'b1; enter_rx = 1'b1;
        repeat (14) step();
        chk_int("simul_space_press_edge", sp_press_edge, S + D);
        chk_int("simul_enter_press_edge", en_press_edge, S + D);
        chk_int("simul_space_press_count", sp_press_cnt, 1);
        chk_int("simul_enter_press_count", en_press_cnt, 1);
        space_rx = 1'b0; enter_rx = 1'b0;
        repeat (14) step();

        // Reset held across edges 6 and 7 while ENTER is counting.
        clear_obs();
        enter_rx = 1'b1;
        repeat (5) step();
        rst = 1'b1;
        repeat (2) step();
        chk("midreset_enter_level", enter_level, 1'b0);
        rst = 1'b0;
        repeat (14) step();
        chk_int("midreset_press_edge",  en_press_edge, 7 + S + D);
        chk_int("midreset_press_count", en_press_cnt, 1);
        enter_rx = 1'b0;
        repeat (14) step();

        // Random line activity with occasional resets.
        hold_s = 0;
        hold_e = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold_s == 0) begin space_rx = 1'($urandom_range(0, 1)); hold_s = $urandom_range(1, 20); end
            if (hold_e == 0) begin enter_rx = 1'($urandom_range(0, 1)); hold_e = $urandom_range(1, 20); end
            hold_s--;
            hold_e--;
            rst = ($urandom_range(0, 499) == 0);
            step();
        end
        rst = 1'b0;
        repeat (4) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_remote_link_rx

// File: doc/remote_link_rx.md
# remote_link_rx

Input conditioning stage for the two-wire board-to-board link carrying the opponent's SPACE and ENTER key levels. It takes the raw asynchronous `space_rx` and `enter_rx` pins, synchronises them into the 65 MHz domain, debounces them, and produces clean levels plus single-cycle press/release pulses. Its outputs feed the remote turn FSM (space level) and the game FSM (enter level/press) in place of the raw pin OR-ed with the board button.

## Interface
- `SYNC_STAGES`, default 2: flip-flops in each synchroniser chain; must be ≥ 2.
- `DEBOUNCE_CYCLES`, default 65000 (1 ms at 65 MHz): consecutive cycles a new value must persist before it is accepted; must be ≥ 1.

- `clk` in 1: 65 MHz system clock.
- `rst` in 1: reset, synchronous and active-high.
- `space_rx` in 1: raw remote SPACE line, asynchronous.
- `enter_rx` in 1: raw remote ENTER line, asynchronous.
- `space_level` out 1: debounced SPACE level.
- `enter_level` out 1: debounced ENTER level.
- `space_press` out 1: one-cycle pulse on the `space_level` 0→1 transition.
- `space_release` out 1: one-cycle pulse on the `space_level` 1→0 transition.
- `enter_press` out 1: one-cycle pulse on the `enter_level` 0→1 transition.
- `enter_release` out 1: one-cycle pulse on the `enter_level` 1→0 transition.

## Operation
- The two channels are identical and fully independent. Simultaneous activity on both is processed without interaction.
- Synchroniser: `SYNC_STAGES` flops in series, all cleared to 0 by reset. The last stage is called `sync`.
- Debouncer state per channel:
  - stable value `s` (drives `*_level`);
  - counter `cnt`, width $clog2(DEBOUNCE_CYCLES+1).
- Per-cycle rule:
  - If `sync == s`: `cnt <= 0`.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: `s <= sync`, `cnt <= 0`, and the matching press pulse (0→1) or release pulse (1→0) is asserted for that cycle only.
  - Else: `cnt <= cnt+1`.
- A bounce or glitch shorter than `DEBOUNCE_CYCLES` cycles returns `sync` to `s`. This clears `cnt` and leaves no effect on any output.
- The counter never wraps. It is bounded by the accept condition.
- Pulses are registered. A press and a release can never occur in the same cycle on one channel. At most one pulse occurs per channel per `DEBOUNCE_CYCLES` cycles.
- Reset mid-operation:
  - all outputs go to 0 on the next edge;
  - a pulse in flight is dropped;
  - partial counts are discarded.
- Reset exit with the line already high: this is treated as a fresh 0→1 transition, so `*_press` fires after the normal latency.

## Timing
- Reset values: `space_level`, `enter_level`, and all four pulses are 0; `cnt` is 0; `s` is 0; all sync flops are 0.
- Latency: number the first rising edge that samples a new stable raw value as edge 1. The level and its pulse update at edge `SYNC_STAGES + DEBOUNCE_CYCLES`. With the defaults this is edge 65002.
- Pulse width is exactly one clock.
- There is no combinational path from any input to any output.

## Structure
- `LINK_DEBOUNCE_CYCLES` (65000) and `LINK_SYNC_STAGES` (2) belong in the shared game package as the design-wide defaults.
- One sub-module, `link_debounce`, covers a single channel: synchroniser, debouncer, and edge pulses. `remote_link_rx` instantiates it twice.
- The top level replaces `ENTER_RX || btn_enter_remote` with `enter_level || btn_enter_remote`, and does the same for the space channel.

## Test plan
- Bench parameters for all scenarios: `DEBOUNCE_CYCLES=8`, `SYNC_STAGES=2`.
- Clean press: raise `space_rx` before edge 1 and hold → `space_level` goes 1 and `space_press`=1 at edge 10 only; `space_release` stays 0.
- Glitch rejection: `enter_rx` high for 7 cycles then low → `enter_level` stays 0 throughout; no pulses.
- Bounce then settle: `space_rx` toggles every 3 cycles for 30 cycles, then holds 1 → exactly one `space_press`, occurring 10 edges after the final rising toggle.
- Release: with `space_level`=1, drop `space_rx` and hold → `space_level`=0 and `space_release`=1 for one cycle at edge 10.
- Independence and simultaneity: raise both lines on the same edge → `space_press` and `enter_press` both pulse on the same cycle (edge 10).
- Reset mid-count: hold `enter_rx` high, assert `rst` at edge 6, deassert at edge 7 with the line still high → no pulse before reset; `enter_press` occurs at edge 7+10 = 17, counted from the first post-reset sampling edge.
